// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared constants and entry type for the instruction fetch stage
package inst_fetch_unit_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// fetch_fifo: parametric synchronous FIFO with push, pop, flush and occupancy count
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC sequencing, credit-limited instruction memory reads and a
// small {pc, inst} buffer toward the decoder, with wrong-path squash on redirect.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0]   pc_q, pc_d, aq_addr;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d, inflight, fifo_cnt;
  logic [CW:0]   occ;
  logic          pop, gnt, keep;
  fetch_entry_t  head, entry_in;
  // the issued-address queue depth always equals the number of requests in flight
  fetch_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk(clk), .rst_n(rst_n), .push_i(gnt), .pop_i(imem_rvalid), .flush_i(1'b0),
    .data_i(pc_q), .data_o(aq_addr), .count_o(inflight)
  );
  fetch_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk(clk), .rst_n(rst_n), .push_i(keep), .pop_i(pop), .flush_i(redirect_valid),
    .data_i(entry_in), .data_o(head), .count_o(fifo_cnt)
  );
  assign pop       = out_valid & out_ready;
  assign occ       = (CW+1)'(inflight) + (CW+1)'(fifo_cnt) - (CW+1)'(pop);
  assign imem_req  = rst_n & ~redirect_valid & (occ < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign gnt       = imem_req & imem_gnt;
  assign keep      = imem_rvalid & ~redirect_valid & (drop_cnt_q == '0);
  assign entry_in  = '{pc: aq_addr, inst: imem_rdata};
  assign out_valid = (fifo_cnt != '0) & ~redirect_valid;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  always_comb begin
    pc_d       = redirect_valid ? (redirect_pc & ~32'd3) : gnt ? pc_q + 32'd4 : pc_q;
    drop_cnt_d = redirect_valid ? inflight - CW'(imem_rvalid)
                                : drop_cnt_q - CW'(imem_rvalid && drop_cnt_q != '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized memory/decoder environment checked against a
// queue-based model of the fetch stage's observable behaviour.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic        clk = 0, rst_n = 0;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, out_inst, out_pc;
  logic        redirect_valid = 0, out_valid, out_ready = 0;
  always #5 clk = ~clk;
  inst_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );
  typedef struct {
    logic [31:0] addr;
    int          rdy;
    bit          stale;
  } req_t;
  req_t        pend[$];
  logic [31:0] popped[$];
  int          checks = 0, errors = 0, cyc = 0, buffered = 0;
  int          gnt_pct = 100, rdy_pct = 100, rv_pct = 100, lat_max = 1;
  logic [31:0] exp_req = RPC, exp_out = RPC;
  bit          s_req, s_ov;
  logic [31:0] s_addr, s_pc;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ NOP_INST ^ 32'h5A5A_0000;
  endfunction
  function automatic int stale_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].stale) n++;
    return n;
  endfunction
  // one clock of environment: memory, decoder, optional redirect, plus model checks
  task automatic step(input bit redir, input logic [31:0] rpc);
    bit rv, exp_ov, pop, exp_rq, g;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    g              = ($urandom_range(99) < gnt_pct);
    imem_gnt       = g;
    out_ready      = ($urandom_range(99) < rdy_pct);
    rv             = pend.size() > 0 && pend[0].rdy <= cyc && $urandom_range(99) < rv_pct;
    imem_rvalid    = rv;
    imem_rdata     = rv ? memf(pend[0].addr) : $urandom;
    #1;
    exp_ov = buffered != 0 && !redir;
    pop    = exp_ov && out_ready;
    exp_rq = !redir && (pend.size() + buffered - int'(pop) < 2);
    s_req = imem_req; s_ov = out_valid; s_addr = imem_addr; s_pc = out_pc;
    checks++;
    if (out_valid !== exp_ov) begin
      errors++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov);
    end
    checks++;
    if (imem_req !== exp_rq) begin
      errors++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_rq);
    end
    if (exp_rq) begin
      checks++;
      if (imem_addr !== exp_req) begin
        errors++;
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, exp_req);
      end
    end
    if (pop) begin
      checks++;
      if (out_pc !== exp_out || out_inst !== memf(exp_out)) begin
        errors++;
        $display("FAIL out_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                 cyc, out_pc, out_inst, exp_out, memf(exp_out));
      end
      popped.push_back(out_pc);
      buffered--;
      exp_out += 32'd4;
    end
    if (rv) begin
      if (!pend[0].stale && !redir) buffered++;
      void'(pend.pop_front());
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1;
      buffered = 0;
      exp_req  = rpc & ~32'd3;
      exp_out  = rpc & ~32'd3;
    end else if (exp_rq && g) begin
      pend.push_back('{exp_req, cyc + int'($urandom_range(1, lat_max)), 1'b0});
      exp_req += 32'd4;
    end
    @(posedge clk);
    cyc++;
  endtask
  task automatic do_reset();
    rst_n = 0; redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0; out_ready = 0;
    pend.delete(); popped.delete();
    buffered = 0; exp_req = RPC; exp_out = RPC;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic test_reset();
    rst_n = 0; redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0; out_ready = 1;
    pend.delete(); popped.delete(); buffered = 0; exp_req = RPC; exp_out = RPC;
    @(negedge clk); #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl req=%b ov=%b exp 0 0", imem_req, out_valid);
    end
    checks++;
    if (out_inst !== 32'h0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL reset_data inst=%h pc=%h exp 0 0", out_inst, out_pc);
    end
    checks++;
    if (imem_addr !== RPC) begin
      errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RPC);
    end
    @(posedge clk); #1 rst_n = 1;
    gnt_pct = 100; rdy_pct = 100; rv_pct = 100; lat_max = 1;
    step(0, 0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== RPC) begin
      errors++; $display("FAIL first_req req=%b addr=%h exp 1 %h", s_req, s_addr, RPC);
    end
  endtask
  task automatic test_stream();
    int first_req = -1, first_ov = -1;
    do_reset();
    gnt_pct = 100; rdy_pct = 100; rv_pct = 100; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      step(0, 0);
      if (s_req && first_req < 0) first_req = i;
      if (s_ov && first_ov < 0) first_ov = i;
    end
    checks++;
    if (first_req != 0 || first_ov != 2) begin
      errors++; $display("FAIL stream_latency req@%0d ov@%0d exp 0 2", first_req, first_ov);
    end
    checks++;
    if (popped.size() != 10) begin
      errors++; $display("FAIL stream_rate got=%0d exp=10", popped.size());
    end
  endtask
  task automatic test_backpressure();
    int n;
    do_reset();
    gnt_pct = 100; rdy_pct = 0; rv_pct = 100; lat_max = 1;
    repeat (10) step(0, 0);
    checks++;
    if (s_req !== 1'b0 || s_ov !== 1'b1 || s_pc !== RPC) begin
      errors++; $display("FAIL bp_full req=%b ov=%b pc=%h exp 0 1 %h", s_req, s_ov, s_pc, RPC);
    end
    rdy_pct = 100;
    n = 0;
    while (popped.size() < 2 && n < 20) begin step(0, 0); n++; end
    checks++;
    if (popped.size() < 2) begin
      errors++; $display("FAIL bp_drain got=%0d exp>=2", popped.size());
    end else if (popped[0] !== RPC || popped[1] !== RPC + 32'd4) begin
      errors++; $display("FAIL bp_drain got=%h,%h exp=%h,%h", popped[0], popped[1], RPC, RPC + 32'd4);
    end
  endtask
  task automatic test_redirect();
    int n = 0;
    bit hit = 0;
    do_reset();
    gnt_pct = 70; rdy_pct = 50; rv_pct = 70; lat_max = 3;
    while (!hit && n < 300) begin
      if (buffered >= 1 && pend.size() + buffered == 2) begin
        popped.delete();
        step(1, 32'h100);
        hit = 1;
      end else step(0, 0);
      n++;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL redir_setup got=0 exp=1"); end
    #1;
    checks++;
    if (int'(dut.drop_cnt_q) != stale_cnt()) begin
      errors++; $display("FAIL redir_drop got=%0d exp=%0d", dut.drop_cnt_q, stale_cnt());
    end
    n = 0;
    while (popped.size() == 0 && n < 60) begin step(0, 0); n++; end
    checks++;
    if (popped.size() == 0 || popped[0] !== 32'h100) begin
      errors++; $display("FAIL redir_target got=%h exp=100", popped.size() ? popped[0] : 32'hx);
    end
  endtask
  task automatic test_redirect_rvalid();
    int n = 0;
    bit hit = 0;
    do_reset();
    gnt_pct = 100; rdy_pct = 100; rv_pct = 100; lat_max = 1;
    while (!hit && n < 30) begin
      if (pend.size() > 0 && pend[0].rdy <= cyc && buffered > 0) begin
        popped.delete();
        step(1, 32'h300);
        hit = 1;
      end else step(0, 0);
      n++;
    end
    checks++;
    if (!hit || popped.size() != 0) begin
      errors++; $display("FAIL rvredir_pop hit=%b pops=%0d exp 1 0", hit, popped.size());
    end
    #1;
    checks++;
    if (int'(dut.drop_cnt_q) != stale_cnt()) begin
      errors++; $display("FAIL rvredir_drop got=%0d exp=%0d", dut.drop_cnt_q, stale_cnt());
    end
    n = 0;
    while (popped.size() == 0 && n < 20) begin step(0, 0); n++; end
    checks++;
    if (popped.size() == 0 || popped[0] !== 32'h300) begin
      errors++; $display("FAIL rvredir_target got=%h exp=300", popped.size() ? popped[0] : 32'hx);
    end
  endtask
  task automatic test_align_wrap();
    do_reset();
    gnt_pct = 100; rdy_pct = 100; rv_pct = 100; lat_max = 1;
    repeat (3) step(0, 0);
    step(1, 32'h203);
    step(0, 0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h200) begin
      errors++; $display("FAIL align req=%b addr=%h exp 1 200", s_req, s_addr);
    end
    step(0, 0);
    step(0, 0);
    checks++;
    if (s_ov !== 1'b1 || s_pc !== 32'h200) begin
      errors++; $display("FAIL redir_latency ov=%b pc=%h exp 1 200", s_ov, s_pc);
    end
    step(1, 32'hFFFF_FFFC);
    step(0, 0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top req=%b addr=%h exp 1 fffffffc", s_req, s_addr);
    end
    step(0, 0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_zero req=%b addr=%h exp 1 0", s_req, s_addr);
    end
    repeat (4) step(0, 0);
  endtask
  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    gnt_pct = 100; rdy_pct = 100; rv_pct = 100; lat_max = 3;
    while (pend.size() != 2 && n < 40) begin step(0, 0); n++; end
    checks++;
    if (pend.size() != 2) begin errors++; $display("FAIL rstmid_setup got=%0d exp=2", pend.size()); end
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL rstmid_clear ov=%b req=%b pc=%h exp 0 0 0", out_valid, imem_req, out_pc);
    end
    do_reset();
    step(0, 0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== RPC) begin
      errors++; $display("FAIL rstmid_restart req=%b addr=%h exp 1 %h", s_req, s_addr, RPC);
    end
    n = 0;
    while (popped.size() == 0 && n < 20) begin step(0, 0); n++; end
    checks++;
    if (popped.size() == 0 || popped[0] !== RPC) begin
      errors++; $display("FAIL rstmid_first got=%h exp=%h", popped.size() ? popped[0] : 32'hx, RPC);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        rdy_pct = $urandom_range(20, 100);
        rv_pct  = $urandom_range(30, 100);
        lat_max = $urandom_range(1, 4);
      end
      step($urandom_range(99) < 4, $urandom);
    end
    checks++;
    if (popped.size() < 100) begin
      errors++; $display("FAIL random_progress got=%0d exp>=100", popped.size());
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_rvalid();
    test_align_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
